argmax_10_16: RTL and testbench

ARGMAX_10_16 -- requirements
Module: argmax_10_16

---
 rtl/argmax_10_16.sv | 107 ++++++++++
 tb/tb_argmax_10_16.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_10_16.sv
// Streaming argmax: collects M signed elements over a valid/ready input,
// then presents the index and value of the largest one over a valid/ready
// output. Ties keep the lowest index. Requires 2**IDXW >= M and WIDTH >= IDXW.
module argmax_10_16 #(
    parameter int WIDTH = 16,
    parameter int M     = 10,
    parameter int IDXW  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_x,
    input  logic                    s_valid_x,
    output logic                    s_ready_x,
    output logic        [WIDTH-1:0] m_data_out_y,
    output logic signed [WIDTH-1:0] m_max_out,
    output logic                    m_valid_y,
    input  logic                    m_ready_y
);

    typedef enum logic {
        ST_COLLECT,
        ST_OUTPUT
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

    state_t                  state;
    state_t                  state_next;
    logic        [IDXW-1:0]  cnt;
    logic signed [WIDTH-1:0] run_max;
    logic        [IDXW-1:0]  run_idx;

    logic                    accept;
    logic                    last_elem;
    logic                    take_new;
    logic signed [WIDTH-1:0] new_max;
    logic        [IDXW-1:0]  new_idx;

    assign accept    = s_valid_x && s_ready_x;
    assign last_elem = (cnt == LAST_IDX);

    // The first element of a vector always wins; later ones need a strictly
    // greater signed value, so equal values leave the earlier index in place.
    assign take_new = (cnt == '0) || (s_data_in_x > run_max);
    assign new_max  = take_new ? s_data_in_x : run_max;
    assign new_idx  = take_new ? cnt : run_idx;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs, decoded from the registered state so
    // ready/valid never depend combinationally on the partner's signal.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        s_ready_x  = 1'b0;
        m_valid_y  = 1'b0;
        case (state)
            ST_COLLECT: begin
                s_ready_x = 1'b1;
                if (s_valid_x && last_elem) begin
                    state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                m_valid_y = 1'b1;
                if (m_ready_y) begin
                    state_next = ST_COLLECT;
                end
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    // Element counter, running max/index and the result registers; nothing
    // moves without an accepted element, so idle gaps and output stalls are
    // lossless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            run_max      <= '0;
            run_idx      <= '0;
            m_max_out    <= '0;
            m_data_out_y <= '0;
        end else if (accept) begin
            run_max <= new_max;
            run_idx <= new_idx;
            if (last_elem) begin
                cnt          <= '0;
                m_max_out    <= new_max;
                m_data_out_y <= WIDTH'(new_idx);
            end else begin
                cnt <= cnt + IDXW'(1);
            end
        end
    end

endmodule

// File: tb/tb_argmax_10_16.sv
// Directed bench for argmax_10_16: reset values, latency, ties, full negative
// range, output stalls, idle gaps, asynchronous reset mid-vector and during
// output, and a short run of random vectors with random handshakes.
module tb_argmax_10_16;

    localparam int M = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] s_data_in_x;
    logic               s_valid_x;
    logic               s_ready_x;
    logic        [15:0] m_data_out_y;
    logic signed [15:0] m_max_out;
    logic               m_valid_y;
    logic               m_ready_y;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_results = 0;
    int base;
    int vec [M];
    int exp_idx;
    int exp_max;

    argmax_10_16 dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (s_ready_x),
        .m_data_out_y (m_data_out_y),
        .m_max_out    (m_max_out),
        .m_valid_y    (m_valid_y),
        .m_ready_y    (m_ready_y)
    );

    always #5 clk = ~clk;

    // Count output handshakes.
    always @(posedge clk) begin
        if (reset && m_valid_y && m_ready_y) n_results++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Present one element and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [15:0] v);
        bit rdy;
        bit done;
        done = 1'b0;
        s_valid_x   = 1'b1;
        s_data_in_x = v;
        for (int t = 0; t < 100 && !done; t++) begin
            rdy = s_ready_x;
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
        end
        s_valid_x = 1'b0;
        if (!done) check("send_timeout", 16'(done), 16'd1);
    endtask

    // Send all of vec with 0..max_gap idle cycles before each element.
    task automatic send_vec(input int max_gap);
        for (int i = 0; i < M; i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                @(posedge clk);
                #1;
            end
            send(16'(vec[i]));
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int t = 0; t < 100 && !m_valid_y; t++) begin
            @(posedge clk);
            #1;
        end
        check(tag, 16'(m_valid_y), 16'd1);
    endtask

    // Complete the output handshake, optionally with random stall cycles.
    task automatic take_result(input bit random_stall, input string tag);
        bit rdy;
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            rdy       = random_stall ? 1'($urandom_range(1, 0)) : 1'b1;
            m_ready_y = rdy;
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
        end
        m_ready_y = 1'b0;
        check({tag, "_valid_drop"}, 16'(m_valid_y), 16'd0);
        check({tag, "_ready_back"}, 16'(s_ready_x), 16'd1);
    endtask

    task automatic check_result(input string tag, input int idx, input int mx);
        check({tag, "_idx"}, m_data_out_y, 16'(idx));
        check({tag, "_max"}, m_max_out, 16'(mx));
    endtask

    initial begin
        reset       = 1'b0;
        s_valid_x   = 1'b0;
        s_data_in_x = '0;
        m_ready_y   = 1'b0;

        // Reset state.
        #2;
        check("rst_valid", 16'(m_valid_y), 16'd0);
        check("rst_ready", 16'(s_ready_x), 16'd1);
        check("rst_idx", m_data_out_y, 16'd0);
        check("rst_max", m_max_out, 16'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready", 16'(s_ready_x), 16'd1);
        check("rel_valid", 16'(m_valid_y), 16'd0);
        check("rel_no_result", 16'(n_results), 16'd0);

        // Back-to-back stream, downstream always ready; tie on 12 keeps index 2.
        m_ready_y = 1'b1;
        vec = '{3, -7, 12, 5, 12, 0, -1, 9, 2, 4};
        for (int i = 0; i < M - 1; i++) send(16'(vec[i]));
        check("t1_no_early_valid", 16'(m_valid_y), 16'd0);
        send(16'(vec[M-1]));
        check("t1_latency_valid", 16'(m_valid_y), 16'd1);
        check("t1_ready_low", 16'(s_ready_x), 16'd0);
        check_result("t1", 2, 12);
        @(posedge clk);
        #1;
        check("t1_valid_drop", 16'(m_valid_y), 16'd0);
        check("t1_ready_back", 16'(s_ready_x), 16'd1);
        check("t1_one_result", 16'(n_results), 16'd1);
        m_ready_y = 1'b0;

        // Most negative value everywhere.
        vec = '{default: -32768};
        send_vec(0);
        wait_valid("t2_valid");
        check_result("t2", 0, 32'h8000);
        take_result(1'b0, "t2");

        // Ascending vector, output stalled 20 cycles with extra input offered.
        for (int i = 0; i < M; i++) vec[i] = i;
        send_vec(0);
        wait_valid("t3_valid");
        s_valid_x   = 1'b1;
        s_data_in_x = 16'sd100;
        repeat (20) begin
            @(posedge clk);
            #1;
            check("t3_stall_valid", 16'(m_valid_y), 16'd1);
            check("t3_stall_ready", 16'(s_ready_x), 16'd0);
            check_result("t3_stall", 9, 9);
        end
        s_valid_x = 1'b0;
        take_result(1'b0, "t3");

        // All negative with a tie on -1 at indices 4 and 6.
        vec = '{-5, -3, -9, -3, -1, -2, -1, -8, -4, -6};
        send_vec(0);
        wait_valid("t3b_valid");
        check_result("t3b", 4, -1);
        take_result(1'b0, "t3b");

        // Idle gaps between elements; max at index 0, tied at 2 and 9.
        vec = '{20, 19, 20, 5, 5, 5, 5, 5, 5, 20};
        send_vec(3);
        wait_valid("t4_valid");
        check_result("t4", 0, 20);
        take_result(1'b1, "t4");

        // Asynchronous reset mid-vector discards the partial vector (holds 99).
        base = n_results;
        send(16'sd10);
        send(16'sd99);
        send(16'sd3);
        send(16'sd4);
        #3 reset = 1'b0;
        #1;
        check("t5_rst_valid", 16'(m_valid_y), 16'd0);
        check("t5_rst_ready", 16'(s_ready_x), 16'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        m_ready_y = 1'b1;
        vec = '{1, 1, 1, 1, 1, 1, 1, 1, 50, 1};
        send_vec(0);
        check("t5_valid", 16'(m_valid_y), 16'd1);
        check_result("t5", 8, 50);
        @(posedge clk);
        #1;
        check("t5_one_result", 16'(n_results - base), 16'd1);
        m_ready_y = 1'b0;

        // Asynchronous reset while a result is pending.
        for (int i = 0; i < M; i++) vec[i] = i;
        send_vec(0);
        wait_valid("t6_pending");
        #3 reset = 1'b0;
        #1;
        check("t6_rst_valid", 16'(m_valid_y), 16'd0);
        check("t6_rst_ready", 16'(s_ready_x), 16'd1);
        check("t6_rst_idx", m_data_out_y, 16'd0);
        check("t6_rst_max", m_max_out, 16'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        vec = '{7, -2, 7, 30, -30, 30, 0, 1, 29, 8};
        send_vec(1);
        wait_valid("t6_valid");
        check_result("t6", 3, 30);
        take_result(1'b1, "t6");

        // Random vectors, random input gaps and output stalls.
        for (int v = 0; v < 20; v++) begin
            for (int i = 0; i < M; i++) vec[i] = int'($urandom_range(65535, 0)) - 32768;
            exp_idx = 0;
            exp_max = vec[0];
            for (int i = 1; i < M; i++) begin
                if (vec[i] > exp_max) begin
                    exp_max = vec[i];
                    exp_idx = i;
                end
            end
            send_vec(1);
            wait_valid("rnd_valid");
            check_result("rnd", exp_idx, exp_max);
            take_result(1'b1, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
